alu_bcd_sequencer: RTL and testbench

//  Multi-cycle ADC/SBC sequencer that owns the 8-bit ALU's operand, op and carry inputs.

---
 rtl/alu_bcd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_alu_bcd_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bcd_sequencer.sv
// rtl/alu_bcd_sequencer.sv - multi-cycle ADC/SBC sequencer with BCD adjust driving a shared 8-bit ALU
//
// Owns the ALU operand, op and carry-in lines. Binary mode runs one add/sub
// step. Decimal mode runs the binary step, then a low-nibble and a
// high-nibble adjust step, both as plain adds through the same ALU.
//
// Build option: ALU_BCD_SEQ_SKIP_EN - when defined, decimal adjust steps whose
// addend would be 8'h00 are skipped. Results and flags do not change.
//
// Parameter:
//   ALU_WAIT      extra hold cycles per ALU step (0..3)
// Ports:
//   clk, reset    clock (rising edge), async active-high reset
//   start         request, accepted in IDLE or DONE
//   op_sub        0 = ADC, 1 = SBC
//   d_flag        decimal mode
//   opa, opb      operands A and M (8 bit)
//   c_in          carry flag in
//   busy          request in progress
//   done          one-cycle completion pulse
//   result        final value (8 bit), held until the next completion
//   c_out,z,n,v   final flags, held with result
//   alu_a, alu_b  ALU operands (8 bit)
//   alu_op        4'h2 add, 4'h3 sub (ALU inverts alu_a)
//   alu_cin       ALU carry in
//   alu_y         ALU result (8 bit)
//   alu_cout      ALU carry out
//   alu_overflow  ALU signed overflow
module alu_bcd_sequencer #(
  parameter int ALU_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op_sub,
  input  logic       d_flag,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  input  logic       c_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       c_out,
  output logic       z,
  output logic       n,
  output logic       v,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  input  logic [7:0] alu_y,
  input  logic       alu_cout,
  input  logic       alu_overflow
);

  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [1:0] WAIT_LAST = 2'(ALU_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIN,
    S_ADJ_LO,
    S_ADJ_HI,
    S_DONE
  } state_t;

  state_t     state_q;
  logic [1:0] cnt_q;
  logic       issued_q;

  // Operands and mode latched at accept
  logic [7:0] a_q;
  logic [7:0] m_q;
  logic       c_q;
  logic       sub_q;
  logic       dec_q;

  // Intermediate step flags
  logic       bin_c_q;
  logic       lo_c_q;
  logic       v_bin_q;

  // Registered outputs
  logic       busy_q;
  logic       done_q;
  logic [7:0] result_q;
  logic       c_out_q;
  logic       z_q;
  logic       n_q;
  logic       v_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_op_q;
  logic       alu_cin_q;

  // High-nibble addend from the step result it follows
  function automatic logic [7:0] hi_addend(input logic sub, input logic bin_c,
                                           input logic lo_c, input logic [7:0] r);
    if (sub) begin
      hi_addend = bin_c ? 8'h00 : 8'hA0;
    end else begin
      hi_addend = (bin_c || lo_c || (r[7:4] > 4'd9)) ? 8'h60 : 8'h00;
    end
  endfunction

  // Half carry is recomputed from the latched operands rather than taken
  // from the ALU, which only reports the full-width carry.
  logic [4:0] hc_sum;
  logic       hc;
  logic [3:0] m_lo;

  assign m_lo   = sub_q ? ~m_q[3:0] : m_q[3:0];
  assign hc_sum = {1'b0, a_q[3:0]} + {1'b0, m_lo} + {4'b0000, c_q};
  assign hc     = hc_sum[4];

  logic step_last;
  logic capture;

  assign step_last = (cnt_q == WAIT_LAST);
  // The first BIN cycle only launches the operands, so the ALU result is
  // captured on the last hold cycle after launch.
  assign capture = step_last &&
                   (((state_q == S_BIN) && issued_q) ||
                    (state_q == S_ADJ_LO) || (state_q == S_ADJ_HI));

  // Low-nibble addend; alu_y holds the BIN result in the BIN capture cycle
  logic [7:0] lo_b;

  always_comb begin
    lo_b = 8'h00;
    if (sub_q) begin
      if (!hc) lo_b = 8'hFA;
    end else if (hc || (alu_y[3:0] > 4'd9)) begin
      lo_b = 8'h06;
    end
  end

  // Next step and the carry that would be reported if finishing now
  state_t     step_d;
  logic [7:0] addend_d;
  logic       carry_d;
  logic       v_d;

  always_comb begin
    step_d   = S_DONE;
    addend_d = 8'h00;
    carry_d  = bin_c_q;
    v_d      = v_bin_q;
    case (state_q)
      S_BIN: begin
        carry_d = alu_cout;
        v_d     = alu_overflow;
        if (dec_q) begin
`ifdef ALU_BCD_SEQ_SKIP_EN
          if (lo_b != 8'h00) begin
            step_d   = S_ADJ_LO;
            addend_d = lo_b;
          end else if (hi_addend(sub_q, alu_cout, 1'b0, alu_y) != 8'h00) begin
            step_d   = S_ADJ_HI;
            addend_d = hi_addend(sub_q, alu_cout, 1'b0, alu_y);
          end
`else
          step_d   = S_ADJ_LO;
          addend_d = lo_b;
`endif
        end
      end
      S_ADJ_LO: begin
        carry_d = sub_q ? bin_c_q : (bin_c_q | alu_cout);
`ifdef ALU_BCD_SEQ_SKIP_EN
        if (hi_addend(sub_q, bin_c_q, alu_cout, alu_y) != 8'h00) begin
          step_d   = S_ADJ_HI;
          addend_d = hi_addend(sub_q, bin_c_q, alu_cout, alu_y);
        end
`else
        step_d   = S_ADJ_HI;
        addend_d = hi_addend(sub_q, bin_c_q, alu_cout, alu_y);
`endif
      end
      S_ADJ_HI: begin
        // alu_b still carries the high addend applied in this step
        carry_d = sub_q ? bin_c_q : (bin_c_q | lo_c_q | (alu_b_q != 8'h00));
      end
      default: begin
        step_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      issued_q  <= 1'b0;
      a_q       <= 8'h00;
      m_q       <= 8'h00;
      c_q       <= 1'b0;
      sub_q     <= 1'b0;
      dec_q     <= 1'b0;
      bin_c_q   <= 1'b0;
      lo_c_q    <= 1'b0;
      v_bin_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 8'h00;
      c_out_q   <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_op_q  <= OP_ADD;
      alu_cin_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            a_q      <= opa;
            m_q      <= opb;
            c_q      <= c_in;
            sub_q    <= op_sub;
            dec_q    <= d_flag;
            lo_c_q   <= 1'b0;
            issued_q <= 1'b0;
            cnt_q    <= 2'd0;
            busy_q   <= 1'b1;
            state_q  <= S_BIN;
          end
        end
        S_BIN: begin
          if (!issued_q) begin
            // SBC feeds M on alu_a so the ALU's inversion yields A + ~M + c
            issued_q  <= 1'b1;
            cnt_q     <= 2'd0;
            alu_a_q   <= sub_q ? m_q : a_q;
            alu_b_q   <= sub_q ? a_q : m_q;
            alu_op_q  <= sub_q ? OP_SUB : OP_ADD;
            alu_cin_q <= c_q;
          end else if (!step_last) begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_ADJ_LO, S_ADJ_HI: begin
          if (!step_last) cnt_q <= cnt_q + 2'd1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (capture) begin
        cnt_q     <= 2'd0;
        alu_op_q  <= OP_ADD;
        alu_cin_q <= 1'b0;
        if (state_q == S_BIN) begin
          bin_c_q <= alu_cout;
          v_bin_q <= alu_overflow;
        end
        if (state_q == S_ADJ_LO) lo_c_q <= alu_cout;
        if (step_d == S_DONE) begin
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          result_q <= alu_y;
          c_out_q  <= carry_d;
          z_q      <= (alu_y == 8'h00);
          n_q      <= alu_y[7];
          v_q      <= v_d;
        end else begin
          state_q <= step_d;
          alu_a_q <= alu_y;
          alu_b_q <= addend_d;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign c_out   = c_out_q;
  assign z       = z_q;
  assign n       = n_q;
  assign v       = v_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign alu_cin = alu_cin_q;

endmodule

// File: tb/tb_alu_bcd_sequencer.sv
// tb/tb_alu_bcd_sequencer.sv - scoreboard bench for alu_bcd_sequencer (ALU_WAIT 0 and 2)
module tb_alu_bcd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start2;
  logic       op_sub, d_flag, c_in;
  logic [7:0] opa, opb;

  logic       busy0, done0, c0, z0, n0, v0;
  logic [7:0] res0, alu_a0, alu_b0, y0;
  logic [3:0] alu_op0;
  logic       alu_cin0, cout0, ov0;

  logic       busy2, done2, c2, z2, n2, v2;
  logic [7:0] res2, alu_a2, alu_b2, y2;
  logic [3:0] alu_op2;
  logic       alu_cin2, cout2, ov2;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    logic [7:0] res;
    logic [3:0] flags;
    int         edge_n;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: op 3 inverts a, then a + b + cin. Returns {ov, cout, y}.
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op, input logic cin);
    logic [7:0] x;
    logic [8:0] s;
    logic       ov;
    x  = (op == 4'h3) ? ~a : a;
    s  = {1'b0, x} + {1'b0, b} + {8'h00, cin};
    ov = (x[7] == b[7]) && (s[7] != b[7]);
    return {ov, s};
  endfunction

  assign {ov0, cout0, y0} = alu_f(alu_a0, alu_b0, alu_op0, alu_cin0);
  assign {ov2, cout2, y2} = alu_f(alu_a2, alu_b2, alu_op2, alu_cin2);

  alu_bcd_sequencer #(.ALU_WAIT(0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .op_sub(op_sub), .d_flag(d_flag),
    .opa(opa), .opb(opb), .c_in(c_in), .busy(busy0), .done(done0), .result(res0),
    .c_out(c0), .z(z0), .n(n0), .v(v0), .alu_a(alu_a0), .alu_b(alu_b0),
    .alu_op(alu_op0), .alu_cin(alu_cin0), .alu_y(y0), .alu_cout(cout0),
    .alu_overflow(ov0)
  );

  alu_bcd_sequencer #(.ALU_WAIT(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .op_sub(op_sub), .d_flag(d_flag),
    .opa(opa), .opb(opb), .c_in(c_in), .busy(busy2), .done(done2), .result(res2),
    .c_out(c2), .z(z2), .n(n2), .v(v2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_op(alu_op2), .alu_cin(alu_cin2), .alu_y(y2), .alu_cout(cout2),
    .alu_overflow(ov2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Decimal latency depends on whether zero adjust steps are skipped
  function automatic int lat(input int full, input int skip);
`ifdef ALU_BCD_SEQ_SKIP_EN
    return skip;
`else
    return full;
`endif
  endfunction

  // Called at a negedge; the next posedge is the accepting edge.
  // flags = {c, z, n, v}
  task automatic issue(input int which, input string nm, input logic sub, input logic dec,
                       input logic [7:0] a, input logic [7:0] m, input logic c,
                       input logic [7:0] res, input logic [3:0] flags, input int n_lat);
    exp_t e;
    op_sub = sub;
    d_flag = dec;
    opa    = a;
    opb    = m;
    c_in   = c;
    if (which == 0) start0 = 1'b1;
    else start2 = 1'b1;
    e.nm     = nm;
    e.res    = res;
    e.flags  = flags;
    e.edge_n = cyc + 1 + n_lat;
    if (which == 0) q0.push_back(e);
    else q2.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    op_sub = ~sub;
    d_flag = ~dec;
    opa    = ~a;
    opb    = ~m;
    c_in   = ~c;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (q0.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    check(nm, q0.size() + q2.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done0) begin
      if (q0.size() == 0) begin
        check("u0_unexpected_done", 1, 0);
      end else begin
        e = q0.pop_front();
        check({e.nm, "_result"}, res0, e.res);
        check({e.nm, "_flags_czn v"}, {c0, z0, n0, v0}, e.flags);
        check({e.nm, "_done_edge"}, cyc, e.edge_n);
      end
    end
    if (!reset && done2) begin
      if (q2.size() == 0) begin
        check("u2_unexpected_done", 1, 0);
      end else begin
        e = q2.pop_front();
        check({e.nm, "_result"}, res2, e.res);
        check({e.nm, "_flags_czn v"}, {c2, z2, n2, v2}, e.flags);
        check({e.nm, "_done_edge"}, cyc, e.edge_n);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    op_sub = 1'b0;
    d_flag = 1'b0;
    opa    = 8'h00;
    opb    = 8'h00;
    c_in   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy_done", {busy0, done0, busy2, done2}, 4'h0);
    check("rst_result", res0, 8'h00);
    check("rst_flags", {c0, z0, n0, v0}, 4'h0);
    check("rst_alu_ops", {alu_a0, alu_b0}, 16'h0000);
    check("rst_alu_op_cin", {alu_op0, alu_cin0}, 5'b0010_0);
    reset = 1'b0;
    @(negedge clk);

    issue(0, "bin_adc_50_50", 1'b0, 1'b0, 8'h50, 8'h50, 1'b0, 8'hA0, 4'b0011, 2);
    drain("drain_t1");
    issue(0, "dec_adc_58_46", 1'b0, 1'b1, 8'h58, 8'h46, 1'b1, 8'h05, 4'b1001, lat(4, 4));
    drain("drain_t2");
    issue(0, "dec_sbc_46_12", 1'b1, 1'b1, 8'h46, 8'h12, 1'b1, 8'h34, 4'b1000, lat(4, 2));
    drain("drain_t3a");
    issue(0, "dec_sbc_12_21", 1'b1, 1'b1, 8'h12, 8'h21, 1'b1, 8'h91, 4'b0010, lat(4, 3));
    drain("drain_t3b");
    issue(0, "bin_sbc_10_20", 1'b1, 1'b0, 8'h10, 8'h20, 1'b1, 8'hF0, 4'b0010, 2);
    drain("drain_t3c");

    // start while busy is ignored; start in the DONE cycle launches a new op
    issue(0, "dec_adc_25_34", 1'b0, 1'b1, 8'h25, 8'h34, 1'b0, 8'h59, 4'b0000, lat(4, 2));
    check("busy_after_accept", busy0, 1'b1);
    opa    = 8'hFF;
    opb    = 8'hFF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done0) break;
      @(negedge clk);
    end
    check("t4_done_seen", done0, 1'b1);
    issue(0, "bin_adc_80_80", 1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 4'b1101, 2);
    check("busy_stays_high", {busy0, done0}, 2'b10);
    drain("drain_t4");

    // reset while in ADJ_LO aborts with no visible result
    issue(0, "aborted", 1'b0, 1'b1, 8'h58, 8'h46, 1'b1, 8'h05, 4'b1001, 4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy_done", {busy0, done0}, 2'b00);
    check("abort_result", res0, 8'h00);
    check("abort_alu_op", {alu_op0, alu_cin0}, 5'b0010_0);
    q0.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(0, "dec_adc_01_01", 1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, lat(4, 2));
    drain("drain_t5");

    issue(2, "w2_dec_adc_09_01", 1'b0, 1'b1, 8'h09, 8'h01, 1'b0, 8'h10, 4'b0000, lat(10, 7));
    drain("drain_t6a");
    issue(2, "w2_bin_adc_50_50", 1'b0, 1'b0, 8'h50, 8'h50, 1'b0, 8'hA0, 4'b0011, 4);
    drain("drain_t6b");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
